// File: rtl/id_stage.sv
// RV32I decode stage: register-file address drive, operand capture, immediate and control decode into an ID/EX slot.
// Optional macro ID_WB_BYPASS_EN selects a same-cycle writeback bypass; without it the stage stalls on a writeback hit.
module id_stage #(
   parameter int XLEN     = 32,
   parameter int ALU_OP_W = 4
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [XLEN-1:0]     in_pc,
   input  logic [31:0]         in_instr,
   input  logic                flush,
   output logic [4:0]          rs1_addr,
   output logic [4:0]          rs2_addr,
   input  logic [XLEN-1:0]     rs1_data,
   input  logic [XLEN-1:0]     rs2_data,
   input  logic                wb_we,
   input  logic [4:0]          wb_rd,
   input  logic [XLEN-1:0]     wb_data,
   input  logic                ex_ld_valid,
   input  logic [4:0]          ex_ld_rd,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [XLEN-1:0]     out_pc,
   output logic [XLEN-1:0]     out_rs1_val,
   output logic [XLEN-1:0]     out_rs2_val,
   output logic [XLEN-1:0]     out_imm,
   output logic [4:0]          out_rd,
   output logic                out_rd_we,
   output logic [ALU_OP_W-1:0] out_alu_op,
   output logic                out_alu_src_imm,
   output logic                out_mem_rd,
   output logic                out_mem_wr,
   output logic                out_branch,
   output logic                out_illegal
);

   typedef enum logic [3:0] {
      ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR,
      ALU_SRL, ALU_SRA, ALU_OR, ALU_AND, ALU_PASSB
   } alu_op_e;

   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_FENCE  = 7'b0001111;
   localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

   // alt selects SUB (register form only) or SRA/SRAI
   function automatic alu_op_e alu_from_f3(input logic [2:0] f3, input logic alt, input logic reg_form);
      case (f3)
         3'd0:    alu_from_f3 = (alt && reg_form) ? ALU_SUB : ALU_ADD;
         3'd1:    alu_from_f3 = ALU_SLL;
         3'd2:    alu_from_f3 = ALU_SLT;
         3'd3:    alu_from_f3 = ALU_SLTU;
         3'd4:    alu_from_f3 = ALU_XOR;
         3'd5:    alu_from_f3 = alt ? ALU_SRA : ALU_SRL;
         3'd6:    alu_from_f3 = ALU_OR;
         default: alu_from_f3 = ALU_AND;
      endcase
   endfunction

   logic [6:0]      opcode;
   logic [2:0]      f3;
   logic [6:0]      f7;
   logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;

   assign opcode   = in_instr[6:0];
   assign f3       = in_instr[14:12];
   assign f7       = in_instr[31:25];
   assign rs1_addr = in_instr[19:15];
   assign rs2_addr = in_instr[24:20];

   assign imm_i = {{20{in_instr[31]}}, in_instr[31:20]};
   assign imm_s = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
   assign imm_b = {{19{in_instr[31]}}, in_instr[31], in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0};
   assign imm_u = {in_instr[31:12], 12'b0};
   assign imm_j = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12], in_instr[20], in_instr[30:21], 1'b0};

   logic [XLEN-1:0] dec_imm;
   alu_op_e         dec_alu;
   logic            dec_src_imm, dec_rd_we, dec_mem_rd, dec_mem_wr, dec_branch, dec_illegal;
   logic            use_rs1, use_rs2;

   always_comb begin
      // NOTE: every output of this block gets a default first, so no path can infer a latch.
      dec_imm     = '0;
      dec_alu     = ALU_ADD;
      dec_src_imm = 1'b0;
      dec_rd_we   = 1'b0;
      dec_mem_rd  = 1'b0;
      dec_mem_wr  = 1'b0;
      dec_branch  = 1'b0;
      dec_illegal = 1'b0;
      use_rs1     = 1'b0;
      use_rs2     = 1'b0;
      case (opcode)
         OPC_LUI: begin
            dec_imm = imm_u; dec_alu = ALU_PASSB; dec_src_imm = 1'b1; dec_rd_we = 1'b1;
         end
         OPC_AUIPC: begin
            dec_imm = imm_u; dec_src_imm = 1'b1; dec_rd_we = 1'b1;
         end
         OPC_JAL: begin
            dec_imm = imm_j; dec_src_imm = 1'b1; dec_rd_we = 1'b1; dec_branch = 1'b1;
         end
         OPC_JALR: begin
            dec_imm = imm_i; dec_src_imm = 1'b1; dec_rd_we = 1'b1; dec_branch = 1'b1;
            use_rs1 = 1'b1; dec_illegal = (f3 != 3'd0);
         end
         OPC_BRANCH: begin
            dec_imm = imm_b; dec_alu = ALU_SUB; dec_branch = 1'b1;
            use_rs1 = 1'b1; use_rs2 = 1'b1; dec_illegal = (f3 == 3'd2) || (f3 == 3'd3);
         end
         OPC_LOAD: begin
            dec_imm = imm_i; dec_src_imm = 1'b1; dec_rd_we = 1'b1; dec_mem_rd = 1'b1;
            use_rs1 = 1'b1; dec_illegal = (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7);
         end
         OPC_STORE: begin
            dec_imm = imm_s; dec_src_imm = 1'b1; dec_mem_wr = 1'b1;
            use_rs1 = 1'b1; use_rs2 = 1'b1; dec_illegal = (f3 > 3'd2);
         end
         OPC_OP_IMM: begin
            dec_imm = imm_i; dec_src_imm = 1'b1; dec_rd_we = 1'b1; use_rs1 = 1'b1;
            dec_alu = alu_from_f3(f3, in_instr[30], 1'b0);
            if (f3 == 3'd1)      dec_illegal = (f7 != 7'b0000000);
            else if (f3 == 3'd5) dec_illegal = (f7 != 7'b0000000) && (f7 != 7'b0100000);
         end
         OPC_OP: begin
            dec_rd_we = 1'b1; use_rs1 = 1'b1; use_rs2 = 1'b1;
            dec_alu = alu_from_f3(f3, in_instr[30], 1'b1);
            dec_illegal = !((f7 == 7'b0000000) ||
                            ((f7 == 7'b0100000) && ((f3 == 3'd0) || (f3 == 3'd5))));
         end
         OPC_FENCE:  ;
         OPC_SYSTEM: dec_illegal = (f3 != 3'd0);
         default:    dec_illegal = 1'b1;
      endcase
      if (dec_illegal) begin
         dec_rd_we  = 1'b0;
         dec_mem_rd = 1'b0;
         dec_mem_wr = 1'b0;
         dec_branch = 1'b0;
         use_rs1    = 1'b0;
         use_rs2    = 1'b0;
      end
      if (in_instr[11:7] == 5'd0) dec_rd_we = 1'b0;
   end

   logic src_rs1, src_rs2, ld_hit, wb_hit, stall, accept;
   logic [XLEN-1:0] rs1_fwd, rs2_fwd;

   assign src_rs1 = use_rs1 && (rs1_addr != 5'd0);
   assign src_rs2 = use_rs2 && (rs2_addr != 5'd0);
   assign ld_hit  = ex_ld_valid && (ex_ld_rd != 5'd0) &&
                    ((src_rs1 && (ex_ld_rd == rs1_addr)) || (src_rs2 && (ex_ld_rd == rs2_addr)));

`ifdef ID_WB_BYPASS_EN
   assign wb_hit  = 1'b0;
   assign rs1_fwd = (wb_we && (wb_rd != 5'd0) && (wb_rd == rs1_addr)) ? wb_data : rs1_data;
   assign rs2_fwd = (wb_we && (wb_rd != 5'd0) && (wb_rd == rs2_addr)) ? wb_data : rs2_data;
`else
   // Wait one cycle for the register file write to land instead of muxing wb_data in
   assign wb_hit  = wb_we && (wb_rd != 5'd0) &&
                    ((src_rs1 && (wb_rd == rs1_addr)) || (src_rs2 && (wb_rd == rs2_addr)));
   assign rs1_fwd = rs1_data;
   assign rs2_fwd = rs2_data;
`endif

   assign stall    = in_valid && (ld_hit || wb_hit);
   assign in_ready = !flush && !stall && (!out_valid || out_ready);
   assign accept   = in_valid && in_ready;

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid       <= 1'b0;
         out_pc          <= '0;
         out_rs1_val     <= '0;
         out_rs2_val     <= '0;
         out_imm         <= '0;
         out_rd          <= '0;
         out_rd_we       <= 1'b0;
         out_alu_op      <= '0;
         out_alu_src_imm <= 1'b0;
         out_mem_rd      <= 1'b0;
         out_mem_wr      <= 1'b0;
         out_branch      <= 1'b0;
         out_illegal     <= 1'b0;
      end else if (flush) begin
         out_valid <= 1'b0;
      end else if (accept) begin
         out_valid       <= 1'b1;
         out_pc          <= in_pc;
         out_rs1_val     <= rs1_fwd;
         out_rs2_val     <= rs2_fwd;
         out_imm         <= dec_imm;
         out_rd          <= in_instr[11:7];
         out_rd_we       <= dec_rd_we;
         out_alu_op      <= dec_alu;
         out_alu_src_imm <= dec_src_imm;
         out_mem_rd      <= dec_mem_rd;
         out_mem_wr      <= dec_mem_wr;
         out_branch      <= dec_branch;
         out_illegal     <= dec_illegal;
      end else if (out_valid && out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_id_stage.sv
// Directed self-checking bench for id_stage; follows ID_WB_BYPASS_EN the same way the design does.
module tb_id_stage;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid, in_ready, flush;
   logic [31:0] in_pc, in_instr;
   logic [4:0]  rs1_addr, rs2_addr;
   logic [31:0] rs1_data, rs2_data;
   logic        wb_we;
   logic [4:0]  wb_rd;
   logic [31:0] wb_data;
   logic        ex_ld_valid;
   logic [4:0]  ex_ld_rd;
   logic        out_valid, out_ready;
   logic [31:0] out_pc, out_rs1_val, out_rs2_val, out_imm;
   logic [4:0]  out_rd;
   logic        out_rd_we;
   logic [3:0]  out_alu_op;
   logic        out_alu_src_imm, out_mem_rd, out_mem_wr, out_branch, out_illegal;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   id_stage dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .in_pc(in_pc), .in_instr(in_instr), .flush(flush),
      .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs1_data(rs1_data), .rs2_data(rs2_data),
      .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
      .ex_ld_valid(ex_ld_valid), .ex_ld_rd(ex_ld_rd),
      .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
      .out_rs1_val(out_rs1_val), .out_rs2_val(out_rs2_val), .out_imm(out_imm),
      .out_rd(out_rd), .out_rd_we(out_rd_we), .out_alu_op(out_alu_op),
      .out_alu_src_imm(out_alu_src_imm), .out_mem_rd(out_mem_rd), .out_mem_wr(out_mem_wr),
      .out_branch(out_branch), .out_illegal(out_illegal)
   );

   // Register file model without internal write-through: writes land at the clock edge
   logic [31:0] rf [32];
   always @(posedge clk) if (wb_we && wb_rd != 5'd0) rf[wb_rd] <= wb_data;
   assign rs1_data = (rs1_addr == 5'd0) ? 32'd0 : rf[rs1_addr];
   assign rs2_data = (rs2_addr == 5'd0) ? 32'd0 : rf[rs2_addr];

   function automatic logic [31:0] rf_init(input logic [4:0] a);
      return (a == 5'd0) ? 32'd0 : 32'h1000 + 32'(a);
   endfunction

   typedef struct packed {
      logic        valid;
      logic [31:0] pc, rs1, rs2, imm;
      logic [4:0]  rd;
      logic        rd_we;
      logic [3:0]  alu;
      logic        src_imm, mem_rd, mem_wr, branch, illegal;
   } out_t;

   typedef struct packed {
      logic [31:0] instr, imm;
      logic        rd_we;
      logic [3:0]  alu;
      logic        src_imm, mem_rd, mem_wr, branch, illegal;
   } dec_t;

   function automatic out_t sample();
      return '{out_valid, out_pc, out_rs1_val, out_rs2_val, out_imm, out_rd, out_rd_we,
               out_alu_op, out_alu_src_imm, out_mem_rd, out_mem_wr, out_branch, out_illegal};
   endfunction

   // Expected slot contents for an instruction read from the initial register file
   function automatic out_t expect_slot(input logic [31:0] pc, input dec_t d);
      logic [31:0] w;
      w = d.instr;
      return '{1'b1, pc, rf_init(w[19:15]), rf_init(w[24:20]), d.imm, w[11:7], d.rd_we,
               d.alu, d.src_imm, d.mem_rd, d.mem_wr, d.branch, d.illegal};
   endfunction

   localparam dec_t ADDI = '{32'h00500093, 32'd5,        1'b1, 4'd0,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
   localparam dec_t LUI  = '{32'h123453B7, 32'h12345000, 1'b1, 4'd10, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};

   task automatic idle();
      in_valid = 1'b0; flush = 1'b0; wb_we = 1'b0; wb_rd = '0; wb_data = '0;
      ex_ld_valid = 1'b0; ex_ld_rd = '0; out_ready = 1'b1; in_pc = '0; in_instr = '0;
   endtask

   task automatic drive(input logic [31:0] pc, input logic [31:0] instr);
      in_valid = 1'b1; in_pc = pc; in_instr = instr;
   endtask

   task automatic check_slot(input string name, input out_t exp);
      out_t got;
      got = sample();
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", name, got, exp);
      end
   endtask

   task automatic check_bit(input string name, input logic got, input logic exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %b want %b", name, got, exp);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      idle();
      #12;
      check_slot("reset_state", '0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check_slot("after_release", '0);
   endtask

   // Back-to-back decode of one instruction per cycle with out_ready held high
   task automatic test_decode();
      dec_t tbl[11];
      tbl[0]  = ADDI;
      tbl[1]  = '{32'h407302B3, 32'd0,        1'b1, 4'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0}; // sub x5,x6,x7
      tbl[2]  = '{32'h40315093, 32'h00000403, 1'b1, 4'd7, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0}; // srai x1,x2,3
      tbl[3]  = '{32'h4062D233, 32'd0,        1'b1, 4'd7, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0}; // sra x4,x5,x6
      tbl[4]  = '{32'hFFC12503, 32'hFFFFFFFC, 1'b1, 4'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0}; // lw x10,-4(x2)
      tbl[5]  = '{32'h00512423, 32'd8,        1'b0, 4'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0}; // sw x5,8(x2)
      tbl[6]  = '{32'hFE208CE3, 32'hFFFFFFF8, 1'b0, 4'd1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0}; // beq x1,x2,-8
      tbl[7]  = LUI;
      tbl[8]  = '{32'hFFFFF0EF, 32'hFFFFFFFE, 1'b1, 4'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0}; // jal x1,-2
      tbl[9]  = '{32'hFFFFFFFF, 32'd0,        1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1}; // illegal
      tbl[10] = '{32'h00208033, 32'd0,        1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0}; // add x0,x1,x2
      for (int i = 0; i <= 11; i++) begin
         if (i < 11) drive(32'h200 + 32'(4 * i), tbl[i].instr);
         else        in_valid = 1'b0;
         if (i > 0) check_slot($sformatf("decode_%0d", i - 1), expect_slot(32'h200 + 32'(4 * (i - 1)), tbl[i - 1]));
         @(negedge clk);
      end
      check_bit("decode_drained", out_valid, 1'b0);
   endtask

   task automatic test_load_use();
      dec_t add_x6 = '{32'h00028333, 32'd0, 1'b1, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      ex_ld_valid = 1'b1; ex_ld_rd = 5'd7;
      drive(32'h300, add_x6.instr);
      #1 check_bit("ld_other_rd_ready", in_ready, 1'b1);
      ex_ld_rd = 5'd5;
      for (int i = 0; i < 3; i++) begin
         #1 check_bit($sformatf("ld_stall_%0d", i), in_ready, 1'b0);
         @(negedge clk);
      end
      check_bit("ld_stall_no_valid", out_valid, 1'b0);
      ex_ld_valid = 1'b0;
      #1 check_bit("ld_release_ready", in_ready, 1'b1);
      @(negedge clk);
      in_valid = 1'b0;
      check_slot("ld_accepted", expect_slot(32'h300, add_x6));
      @(negedge clk);
   endtask

   task automatic test_hold();
      out_t held;
      out_ready = 1'b0;
      drive(32'h400, ADDI.instr);
      @(negedge clk);
      held = expect_slot(32'h400, ADDI);
      drive(32'h404, LUI.instr);
      for (int i = 0; i < 3; i++) begin
         #1 check_bit($sformatf("hold_ready_%0d", i), in_ready, 1'b0);
         check_slot($sformatf("hold_stable_%0d", i), held);
         @(negedge clk);
      end
      out_ready = 1'b1;
      #1 check_bit("hold_release_ready", in_ready, 1'b1);
      @(negedge clk);
      in_valid = 1'b0;
      check_slot("hold_next_loaded", expect_slot(32'h404, LUI));
      @(negedge clk);
   endtask

   task automatic test_flush();
      out_t exp_b;
      out_ready = 1'b0;
      drive(32'h500, ADDI.instr);
      @(negedge clk);
      drive(32'h504, LUI.instr);
      flush = 1'b1;
      #1 check_bit("flush_ready_low", in_ready, 1'b0);
      @(negedge clk);
      flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      check_bit("flush_kills_slot", out_valid, 1'b0);
      @(negedge clk);
      check_bit("flush_input_dropped", out_valid, 1'b0);
      drive(32'h508, LUI.instr);
      @(negedge clk);
      in_valid = 1'b0; out_ready = 1'b0;
      exp_b = expect_slot(32'h508, LUI);
      check_slot("pre_reset_slot", exp_b);
      #2 rst_n = 1'b0;
      #1 check_slot("async_reset_clears", '0);
      @(negedge clk);
      rst_n = 1'b1; out_ready = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_x0_no_bypass();
      wb_we = 1'b1; wb_rd = 5'd0; wb_data = 32'd1;
      drive(32'h600, ADDI.instr);
      #1 check_bit("x0_wb_ready", in_ready, 1'b1);
      @(negedge clk);
      idle();
      check_slot("x0_not_bypassed", expect_slot(32'h600, ADDI));
      @(negedge clk);
   endtask

   task automatic test_wb_bypass();
      dec_t add_x3 = '{32'h002101B3, 32'd0, 1'b1, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      out_t exp;
      exp = expect_slot(32'h700, add_x3);
      exp.rs1 = 32'hDEADBEEF;
      exp.rs2 = 32'hDEADBEEF;
      wb_we = 1'b1; wb_rd = 5'd2; wb_data = 32'hDEADBEEF;
      drive(32'h700, add_x3.instr);
`ifdef ID_WB_BYPASS_EN
      #1 check_bit("wb_bypass_ready", in_ready, 1'b1);
`else
      #1 check_bit("wb_stall_ready", in_ready, 1'b0);
      @(negedge clk);
      wb_we = 1'b0;
      check_bit("wb_stall_no_valid", out_valid, 1'b0);
      #1 check_bit("wb_release_ready", in_ready, 1'b1);
`endif
      @(negedge clk);
      idle();
      check_slot("wb_operands", exp);
      @(negedge clk);
   endtask

   initial begin
      for (int i = 0; i < 32; i++) rf[i] = rf_init(5'(i));
      test_reset();
      test_decode();
      test_load_use();
      test_hold();
      test_flush();
      test_x0_no_bypass();
      test_wb_bypass();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
      $fatal(1);
   end

endmodule
